// File: rtl/key_filter.sv
`default_nettype none
// ============================================================================
//  Module      : key_filter
//  Description : Debounce filter for one mechanical key. The raw key is
//                brought into the clock domain by a two-flop synchronizer.
//                A four-state FSM then accepts a level change only after the
//                new level has held for CNT_MAX consecutive cycles.
//
//  Parameters  : CNT_MAX    - stable cycles needed to accept a change (>= 2)
//                KEY_ACTIVE - raw key_in level that means "pressed"
//
//  Ports       : sys_clk     in   sole clock, rising edge
//                sys_rst     in   synchronous active-high reset
//                key_in      in   raw, bouncing, asynchronous key
//                key_flag    out  one-cycle pulse per accepted press
//                key_release out  one-cycle pulse per accepted release
//                key_state   out  debounced level, 1 = pressed
//                press_cnt   out  8-bit wrapping count of accepted presses
//
//  Revision    : 1.0  initial release
// ============================================================================
module key_filter #(
    parameter int   CNT_MAX    = 999_999,
    parameter logic KEY_ACTIVE = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_in,
    output logic       key_flag,
    output logic       key_release,
    output logic       key_state,
    output logic [7:0] press_cnt
);

    localparam int              CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_FILT   = 2'd1,
        S_DOWN         = 2'd2,
        S_RELEASE_FILT = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_pressed;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept_press;
    logic             w_accept_release;

    // ------------------------------------------------------------------
    // Synchronizer. Both flops reset to the released level so that a key
    // held down through reset is seen as a fresh press afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= ~KEY_ACTIVE;
            r_sync2 <= ~KEY_ACTIVE;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (r_sync2 == KEY_ACTIVE);

    // ------------------------------------------------------------------
    // FSM state and filter counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Any reversion during filtering drops back to the
    // stable state with the counter cleared, so partial counts from a
    // bounce never carry over to the next attempt. The counter stops at
    // C_CNT_LAST and is cleared on acceptance, so it cannot wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = S_PRESS_FILT;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_FILT: begin
                if (!w_pressed) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt    = S_DOWN;
                    w_cnt_nxt      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DOWN: begin
                if (!w_pressed) begin
                    w_state_nxt = S_RELEASE_FILT;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_FILT: begin
                if (w_pressed) begin
                    w_state_nxt = S_DOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt      = S_IDLE;
                    w_cnt_nxt        = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, updated on the same edge as the accepting
    // transition. Press and release acceptance come from different
    // states, so the two pulses are mutually exclusive by construction.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_state   <= 1'b0;
            press_cnt   <= 8'd0;
        end else begin
            key_flag    <= w_accept_press;
            key_release <= w_accept_release;
            if (w_accept_press) begin
                key_state <= 1'b1;
                press_cnt <= press_cnt + 8'd1;
            end else if (w_accept_release) begin
                key_state <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter: CNT_MAX, default 999_999, number of consecutive stable cycles required to accept a level change; legal range >= 2 (20 ms at 50 MHz).
REQ-002 Parameter: KEY_ACTIVE, default 1'b0, raw key_in level meaning "pressed".
REQ-003 Port: sys_clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port: sys_rst, input, 1, synchronous active-high reset, sampled on rising sys_clk.
REQ-005 Port: key_in, input, 1, raw mechanical key, asynchronous to sys_clk, bouncing.
REQ-006 Port: key_flag, output, 1, registered one-cycle pulse per accepted press; drives the downstream toggle FSM "in" input.
REQ-007 Port: key_release, output, 1, registered one-cycle pulse per accepted release.
REQ-008 Port: key_state, output, 1, registered debounced level, 1 = pressed.
REQ-009 Port: press_cnt, output, 8, registered count of accepted presses.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-stage output, normalized to pressed = (sync2 == KEY_ACTIVE).
REQ-011 FSM SHALL have exactly four states: IDLE (stable released), PRESS_FILT, DOWN (stable pressed), RELEASE_FILT.
REQ-012 Filter counter width SHALL be clog2(CNT_MAX+1) bits; it SHALL never exceed CNT_MAX-1 and SHALL NOT wrap.
REQ-013 IDLE: pressed=1 -> PRESS_FILT with counter cleared to 0; otherwise stay.
REQ-014 PRESS_FILT: pressed=0 -> IDLE, counter 0, no output pulse (bounce rejected); pressed=1 and counter==CNT_MAX-1 -> DOWN; otherwise counter+1.
REQ-015 DOWN: pressed=0 -> RELEASE_FILT with counter cleared to 0; otherwise stay.
REQ-016 RELEASE_FILT: pressed=1 -> DOWN, counter 0, no pulse; pressed=0 and counter==CNT_MAX-1 -> IDLE; otherwise counter+1.
REQ-017 On the edge entering DOWN from PRESS_FILT: key_flag=1, key_state=1, press_cnt+1, all on that same edge; key_flag SHALL be 0 on the next edge.
REQ-018 On the edge entering IDLE from RELEASE_FILT: key_release=1, key_state=0; key_release SHALL be 0 on the next edge.
REQ-019 Latency: key_in changing before edge e and then held stable SHALL produce the pulse on edge e+CNT_MAX+2 (2 sync plus CNT_MAX filter).
REQ-020 Any reversion of pressed before the counter reaches CNT_MAX-1 SHALL restart filtering from 0; partial counts SHALL never accumulate across bounces.
REQ-021 key_flag and key_release SHALL never be high in the same cycle; at most one accepted press per accepted release.
REQ-022 press_cnt SHALL wrap 255 -> 0 on the 256th press with no other side effect.
REQ-023 A key held pressed through reset release SHALL be reported as one press, CNT_MAX+2 edges after reset deasserts.

Reset
REQ-024 While sys_rst=1 at a rising edge: state=IDLE, counter=0, both synchronizer flops=~KEY_ACTIVE, key_flag=0, key_release=0, key_state=0, press_cnt=0.
REQ-025 Reset asserted mid-filter or in DOWN SHALL abort without emitting key_flag or key_release.
REQ-026 Outputs SHALL not change between reset edges for any key_in activity.

Verification (CNT_MAX=4, KEY_ACTIVE=0)
REQ-027 Reset 3 cycles, key_in=1 -> all outputs 0, press_cnt=0 throughout.
REQ-028 key_in 1->0 before edge 10, held -> key_flag high only after edge 16, key_state=1 from edge 16, press_cnt=1.
REQ-029 Press with bounce: key_in low 2 cycles, high 1, low 2, high 1, then low held -> exactly one key_flag, 6 edges after last falling change; no pulse before.
REQ-030 Release from DOWN: key_in 0->1 held -> key_release one cycle, 6 edges later; key_state=0; key_flag stays 0.
REQ-031 256 clean press/release pairs -> press_cnt returns to 0, exactly 256 key_flag pulses, 256 key_release pulses.
REQ-032 sys_rst pulsed at counter=2 in PRESS_FILT with key_in held 0 -> no pulse during abort; one key_flag 6 edges after reset deasserts.
